// File: rtl/alu_result_capture_if.sv
// Bundles the start/op/result request and the captured-result/handshake signals
// that pass between the control unit / ALU and the result capture stage.
interface alu_result_capture_if;
   logic        start;
   logic [4:0]  op;
   logic [31:0] result_hi;
   logic [31:0] result_lo;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] z_hi;
   logic [31:0] z_lo;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;
   logic        hilo_wr;

   modport master (
      output start, op, result_hi, result_lo,
      input  busy, done, err, z_hi, z_lo, hi_reg, lo_reg, hilo_wr
   );

   modport slave (
      input  start, op, result_hi, result_lo,
      output busy, done, err, z_hi, z_lo, hi_reg, lo_reg, hilo_wr
   );
endinterface

// File: rtl/alu_result_capture.sv
// Waits the op-dependent ALU latency after start, then captures the ALU result
// into Z (and HI/LO for MUL/DIV) with a registered busy/done/err handshake.
module alu_result_capture #(
   parameter int unsigned MUL_LAT = 17,
   parameter int unsigned DIV_LAT = 1
) (
   input  logic                 clock,
   input  logic                 clear,
   alu_result_capture_if.slave  bus
);

   localparam logic [4:0] OP_FIRST = 5'b00011;
   localparam logic [4:0] OP_LAST  = 5'b10011;
   localparam logic [4:0] OP_DIV   = 5'b01111;
   localparam logic [4:0] OP_MUL   = 5'b10000;
   localparam logic [5:0] MUL_CNT  = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state, state_n;
   logic [5:0]  cnt, cnt_n;
   logic [4:0]  op_q, op_n;
   logic        bad, bad_n;
   logic        busy_q, busy_n;
   logic        done_q, done_n;
   logic        err_q, err_n;
   logic        hilo_q, hilo_n;
   logic [31:0] z_hi_q, z_hi_n;
   logic [31:0] z_lo_q, z_lo_n;
   logic [31:0] hi_q, hi_n;
   logic [31:0] lo_q, lo_n;

   logic legal;
   logic op_hilo;

   assign legal   = (bus.op >= OP_FIRST) && (bus.op <= OP_LAST);
   assign op_hilo = (op_q == OP_MUL) || (op_q == OP_DIV);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         bad    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         hilo_q <= 1'b0;
         z_hi_q <= '0;
         z_lo_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         op_q   <= op_n;
         bad    <= bad_n;
         busy_q <= busy_n;
         done_q <= done_n;
         err_q  <= err_n;
         hilo_q <= hilo_n;
         z_hi_q <= z_hi_n;
         z_lo_q <= z_lo_n;
         hi_q   <= hi_n;
         lo_q   <= lo_n;
      end
   end

   // An illegal op takes one silent pass through WAIT (busy held low, bad set)
   // so its err/done pulse lands one cycle after start, like a single-cycle op.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      op_n    = op_q;
      bad_n   = bad;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      hilo_n  = 1'b0;
      z_hi_n  = z_hi_q;
      z_lo_n  = z_lo_q;
      hi_n    = hi_q;
      lo_n    = lo_q;

      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_n = WAIT;
               if (legal) begin
                  op_n   = bus.op;
                  bad_n  = 1'b0;
                  busy_n = 1'b1;
                  if (bus.op == OP_MUL)
                     cnt_n = MUL_CNT;
                  else if (bus.op == OP_DIV)
                     cnt_n = DIV_CNT;
                  else
                     cnt_n = '0;
               end else begin
                  bad_n = 1'b1;
                  cnt_n = '0;
               end
            end else begin
               state_n = IDLE;
            end
         end

         WAIT: begin
            if (cnt != '0) begin
               cnt_n  = cnt - 6'd1;
               busy_n = 1'b1;
            end else begin
               state_n = DONE;
               done_n  = 1'b1;
               bad_n   = 1'b0;
               if (bad) begin
                  err_n = 1'b1;
               end else begin
                  z_hi_n = bus.result_hi;
                  z_lo_n = bus.result_lo;
                  if (op_hilo) begin
                     hi_n   = bus.result_hi;
                     lo_n   = bus.result_lo;
                     hilo_n = 1'b1;
                  end
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;
   assign bus.hilo_wr = hilo_q;
   assign bus.z_hi    = z_hi_q;
   assign bus.z_lo    = z_lo_q;
   assign bus.hi_reg  = hi_q;
   assign bus.lo_reg  = lo_q;

endmodule
